maxnet_loader: RTL and testbench

Front-end sequencer for the Maxnet core. It accepts a 5-word IEEE-754 single-precision frame (eps, a1..a4) over a valid/ready stream and screens each word for NaN/Inf. It then holds the operands stable on the core's operand ports, issues a one-cycle start, and waits for finish with a timeout. The core's result and overflow are returned to the upstream master through a valid/ready result channel.

---
 rtl/maxnet_pkg.sv | 21 ++
 rtl/maxnet_loader_if.sv | 34 +++
 rtl/maxnet_loader_fp32_check.sv | 12 +
 rtl/maxnet_loader.sv | 102 ++++++++++
 tb/tb_maxnet_loader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared FSM states, result codes and FP32 field constants for the Maxnet loader
package maxnet_pkg;

    typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_BAD = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    localparam logic [2:0] IDX_EPS = 3'd0;
    localparam logic [2:0] IDX_A1  = 3'd1;
    localparam logic [2:0] IDX_A2  = 3'd2;
    localparam logic [2:0] IDX_A3  = 3'd3;
    localparam logic [2:0] IDX_A4  = 3'd4;

endpackage

// File: rtl/maxnet_loader_if.sv
// maxnet_loader_if: operand stream, Maxnet core port and result channel bundle
interface maxnet_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mx_start;
    logic [31:0] mx_eps;
    logic [31:0] mx_a1;
    logic [31:0] mx_a2;
    logic [31:0] mx_a3;
    logic [31:0] mx_a4;
    logic        mx_finish;
    logic        mx_overflow;
    logic [31:0] mx_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_overflow;
    logic [1:0]  res_err;

    modport slave (
        input  in_valid, in_data, mx_finish, mx_overflow, mx_out, res_ready,
        output in_ready, mx_start, mx_eps, mx_a1, mx_a2, mx_a3, mx_a4,
               res_valid, res_data, res_overflow, res_err
    );

    modport master (
        output in_valid, in_data, mx_finish, mx_overflow, mx_out, res_ready,
        input  in_ready, mx_start, mx_eps, mx_a1, mx_a2, mx_a3, mx_a4,
               res_valid, res_data, res_overflow, res_err
    );

endinterface

// File: rtl/maxnet_loader_fp32_check.sv
// fp32_check: flags NaN/Inf words and a non-negative eps
module fp32_check
    import maxnet_pkg::*;
(
    input  logic [31:0] word,
    input  logic        is_eps,
    output logic        bad
);

    assign bad = (word[EXP_MSB:EXP_LSB] == EXP_SPECIAL) || (is_eps && !word[SIGN_BIT]);

endmodule

// File: rtl/maxnet_loader.sv
// maxnet_loader: collects a screened 5-word frame, runs the Maxnet core and returns its result
module maxnet_loader
    import maxnet_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    maxnet_loader_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [2:0]       idx;
    logic             bad;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op [5];
    logic             word_bad;
    logic             frame_bad;

    fp32_check u_chk (
        .word   (bus.in_data),
        .is_eps (idx == IDX_EPS),
        .bad    (word_bad)
    );

    assign frame_bad    = bad || word_bad;
    assign bus.in_ready = state == LOAD;
    assign bus.mx_eps   = op[IDX_EPS];
    assign bus.mx_a1    = op[IDX_A1];
    assign bus.mx_a2    = op[IDX_A2];
    assign bus.mx_a3    = op[IDX_A3];
    assign bus.mx_a4    = op[IDX_A4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= LOAD;
            idx              <= '0;
            bad              <= 1'b0;
            cnt              <= '0;
            op               <= '{default: '0};
            bus.mx_start     <= 1'b0;
            bus.res_valid    <= 1'b0;
            bus.res_err      <= ERR_OK;
            bus.res_data     <= '0;
            bus.res_overflow <= 1'b0;
        end else begin
            case (state)
                LOAD: if (bus.in_valid) begin
                    op[idx] <= bus.in_data;
                    if (idx == IDX_A4) begin
                        state        <= frame_bad ? RESULT : START;
                        bus.mx_start <= !frame_bad;
                        if (frame_bad) begin
                            bus.res_valid    <= 1'b1;
                            bus.res_err      <= ERR_BAD;
                            bus.res_data     <= '0;
                            bus.res_overflow <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 3'd1;
                        bad <= frame_bad;
                    end
                end
                START: begin
                    bus.mx_start <= 1'b0;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    // finish is checked first so it wins over a coincident timeout
                    if (bus.mx_finish) begin
                        state            <= RESULT;
                        bus.res_valid    <= 1'b1;
                        bus.res_err      <= ERR_OK;
                        bus.res_data     <= bus.mx_out;
                        bus.res_overflow <= bus.mx_overflow;
                    end else if (cnt == CNT_LAST) begin
                        state            <= RESULT;
                        bus.res_valid    <= 1'b1;
                        bus.res_err      <= ERR_TMO;
                        bus.res_data     <= '0;
                        bus.res_overflow <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: if (bus.res_ready) begin
                    state         <= LOAD;
                    bus.res_valid <= 1'b0;
                    idx           <= '0;
                    bad           <= 1'b0;
                    cnt           <= '0;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_loader.sv
// tb_maxnet_loader: random frames against a frame-level outcome model, plus directed corner cases
module tb_maxnet_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   starts;
    logic [31:0] frame [5];

    always #5 clk = ~clk;

    maxnet_loader_if f ();
    maxnet_loader_if t ();
    virtual maxnet_loader_if vif;

    maxnet_loader #(.TIMEOUT(64), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(f));
    maxnet_loader #(.TIMEOUT(8),  .CNT_W(16)) dut_t (.clk(clk), .rst(rst), .bus(t));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (vif.mx_start === 1'b1) starts++;
    endtask

    // frame is rejected if any word is NaN/Inf or eps is not negative
    function automatic bit frame_is_bad();
        bit b = frame[0][31] == 1'b0;
        for (int i = 0; i < 5; i++)
            if (frame[i][30:23] == 8'hFF) b = 1'b1;
        return b;
    endfunction

    task automatic send_words(input bit gaps);
        int k = 0;
        int cyc = 0;
        logic v, r;
        while (k < 5 && cyc < 200) begin
            tick();
            v = !gaps || (cyc % 2 == 0);
            vif.in_valid = v;
            vif.in_data  = v ? frame[k] : $urandom;
            r = vif.in_ready;
            @(posedge clk);
            if (v && r) k++;
            cyc++;
        end
        check("accepted", k, 5);
    endtask

    task automatic run_frame(input int tmo, input int lat, input int hold, input bit gaps,
                             input logic [31:0] out, input logic ovf);
        bit bad = frame_is_bad();
        bit ok = lat > 0 && lat <= tmo;
        int n = ok ? lat : tmo;
        logic [1:0] e_err = bad ? 2'b01 : ok ? 2'b00 : 2'b10;
        logic [31:0] e_data = (!bad && ok) ? out : 32'h0;
        logic e_ovf = !bad && ok && ovf;
        starts = 0;
        send_words(gaps);
        tick();
        vif.in_valid = 1'b1;
        vif.in_data  = $urandom;
        check("op_eps", vif.mx_eps, frame[0]);
        check("op_a1", vif.mx_a1, frame[1]);
        check("op_a2", vif.mx_a2, frame[2]);
        check("op_a3", vif.mx_a3, frame[3]);
        check("op_a4", vif.mx_a4, frame[4]);
        check("start_pulse", vif.mx_start, !bad);
        check("valid_after_accept", vif.res_valid, bad);
        if (!bad) begin
            vif.mx_finish = 1'b0;
            for (int i = 0; i < n; i++) begin
                tick();
                check("wait_start", vif.mx_start, 1'b0);
                check("wait_valid", vif.res_valid, 1'b0);
                check("wait_ready", vif.in_ready, 1'b0);
                if (i == lat - 1) begin
                    vif.mx_finish   = 1'b1;
                    vif.mx_out      = out;
                    vif.mx_overflow = ovf;
                end
            end
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) tick();
            check("res_valid", vif.res_valid, 1'b1);
            check("res_err", vif.res_err, e_err);
            check("res_data", vif.res_data, e_data);
            check("res_overflow", vif.res_overflow, e_ovf);
            check("res_in_ready", vif.in_ready, 1'b0);
            check("res_op_hold", vif.mx_a4, frame[4]);
            vif.mx_out = $urandom;
        end
        vif.res_ready = 1'b1;
        tick();
        vif.res_ready = 1'b0;
        vif.in_valid  = 1'b0;
        check("post_valid", vif.res_valid, 1'b0);
        check("post_ready", vif.in_ready, 1'b1);
        check("start_count", starts, bad ? 0 : 1);
    endtask

    task automatic set_nominal();
        frame[0] = 32'hBE4CCCCD;
        frame[1] = 32'h461C3FA7;
        frame[2] = 32'hC61C3FA7;
        frame[3] = 32'h3FA66666;
        frame[4] = 32'hC61C3FA7;
    endtask

    task automatic set_random();
        for (int i = 0; i < 5; i++) begin
            frame[i] = $urandom;
            if ($urandom_range(0, 11) == 0) frame[i][30:23] = 8'hFF;
            else if (frame[i][30:23] == 8'hFF) frame[i][30:23] = 8'h7F;
        end
        frame[0][31] = $urandom_range(0, 7) != 0;
    endtask

    initial begin
        f.in_valid = 0; f.in_data = 0; f.mx_finish = 0; f.mx_overflow = 0; f.mx_out = 0; f.res_ready = 0;
        t.in_valid = 0; t.in_data = 0; t.mx_finish = 0; t.mx_overflow = 0; t.mx_out = 0; t.res_ready = 0;
        vif = f;
        repeat (3) @(negedge clk);
        check("rst_in_ready", f.in_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", f.in_ready, 1'b1);
        check("reset_valid", f.res_valid, 1'b0);
        check("reset_start", f.mx_start, 1'b0);
        check("reset_err", f.res_err, 2'b00);
        check("reset_data", f.res_data, 32'h0);
        check("reset_ovf", f.res_overflow, 1'b0);
        check("reset_eps", f.mx_eps, 32'h0);
        check("reset_a4", f.mx_a4, 32'h0);

        set_nominal();
        run_frame(64, 20, 0, 1'b0, 32'h461C3FA7, 1'b0);
        set_nominal();
        frame[3] = 32'h7FC00000;
        run_frame(64, 20, 2, 1'b0, 32'h12345678, 1'b1);
        set_nominal();
        frame[0] = 32'h3E4CCCCD;
        run_frame(64, 20, 0, 1'b0, 32'h12345678, 1'b0);
        set_nominal();
        run_frame(64, 7, 10, 1'b1, 32'hC0490FDB, 1'b1);
        set_nominal();
        frame[2] = 32'h3F800000;
        run_frame(64, 3, 0, 1'b0, 32'h3F800000, 1'b0);
        set_nominal();
        run_frame(64, 0, 1, 1'b0, 32'h0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            set_random();
            run_frame(64, $urandom_range(0, 9) == 0 ? 70 : $urandom_range(1, 24),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
        end

        // abort in the middle of WAIT, then a clean frame
        set_nominal();
        f.mx_finish = 1'b0;
        send_words(1'b0);
        f.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", f.res_valid, 1'b0);
        check("mid_rst_start", f.mx_start, 1'b0);
        check("mid_rst_err", f.res_err, 2'b00);
        check("mid_rst_data", f.res_data, 32'h0);
        check("mid_rst_eps", f.mx_eps, 32'h0);
        check("mid_rst_a3", f.mx_a3, 32'h0);
        check("mid_rst_ready", f.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        run_frame(64, 20, 0, 1'b0, 32'h461C3FA7, 1'b0);

        vif = t;
        set_nominal();
        run_frame(8, 0, 0, 1'b0, 32'h0, 1'b0);
        set_nominal();
        run_frame(8, 8, 0, 1'b0, 32'h40490FDB, 1'b1);
        set_nominal();
        run_frame(8, 9, 0, 1'b0, 32'h40490FDB, 1'b0);
        set_nominal();
        run_frame(8, 1, 0, 1'b0, 32'hBF800000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
